// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen/sprite defaults, axis FSM state type and centring helper
package sprite_pkg;
  localparam int H_ACTIVE_DEF     = 640;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int OBJ_W_DEF        = 32;
  localparam int OBJ_H_DEF        = 32;
  localparam int STEP_DEF         = 8;
  localparam int REPEAT_DELAY_DEF = 30;
  localparam int REPEAT_RATE_DEF  = 6;
  localparam int POS_W            = 10;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} axis_state_t;
  function automatic int centre(input int active, input int obj);
    return (active - obj) / 2;
  endfunction
endpackage

// File: rtl/axis_stepper.sv
// axis_stepper: one movement axis -- key edge detect, pending step, hold/repeat FSM, clamped position
//   clk, rst (async, active-high), frame_tick : timing
//   key_p / key_n : keys moving towards LIMIT / towards 0
//   pos : position in [0, LIMIT]; hit : clamp pulse; held : OR of registered key levels
//   SPRITE_AUTO_REPEAT_EN : enables the REPEAT state and frame counter
module axis_stepper
  import sprite_pkg::*;
#(
  parameter int LIMIT        = 608,
  parameter int INIT         = 304,
  parameter int STEP         = STEP_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             key_p,
  input  logic             key_n,
  output logic [POS_W-1:0] pos,
  output logic             hit,
  output logic             held
);
  localparam logic signed [10:0] S   = 11'(STEP);
  localparam logic signed [10:0] LIM = 11'(LIMIT);
  axis_state_t state, state_n;
  logic r_p, r_n, first, pend_p, pend_n, fire;
  logic rise_p, rise_n, dir_p, dir_n, go_p, go_n, go;
  logic signed [10:0] sum;
  // first masks edges in the cycle after reset so a key held through reset is not a press
  assign rise_p = key_p & ~r_p & ~first;
  assign rise_n = key_n & ~r_n & ~first;
  assign held   = r_p | r_n;
  assign dir_p  = pend_p | rise_p | (fire & r_p);
  assign dir_n  = pend_n | rise_n | (fire & r_n);
  // a direction steps only if the opposite key is neither requesting nor held
  assign go_p   = frame_tick & dir_p & ~(dir_n | r_n | key_n);
  assign go_n   = frame_tick & dir_n & ~(dir_p | r_p | key_p);
  assign go     = go_p | go_n;
  assign sum    = $signed({1'b0, pos}) + (go_n ? -S : S);
`ifdef SPRITE_AUTO_REPEAT_EN
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [CW-1:0] cnt, cnt_n;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        state_n = (rise_p | rise_n) ? HELD : IDLE;
        cnt_n   = '0;
      end
      HELD: begin
        if (!held) begin
          state_n = (rise_p | rise_n) ? HELD : IDLE;
          cnt_n   = '0;
        end else if (frame_tick) begin
          // preload so the first frame in REPEAT already fires
          state_n = (cnt + 1'b1 == CW'(REPEAT_DELAY)) ? REPEAT : HELD;
          cnt_n   = (cnt + 1'b1 == CW'(REPEAT_DELAY)) ? CW'(REPEAT_RATE - 1) : cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!held) begin
          state_n = (rise_p | rise_n) ? HELD : IDLE;
          cnt_n   = '0;
        end else if (frame_tick) begin
          fire  = cnt == CW'(REPEAT_RATE - 1);
          cnt_n = fire ? '0 : cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt_n;
`else
  assign fire    = 1'b0;
  assign state_n = (rise_p | rise_n | (state == HELD && held)) ? HELD : IDLE;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      first  <= 1'b1;
      r_p    <= 1'b0;
      r_n    <= 1'b0;
      pend_p <= 1'b0;
      pend_n <= 1'b0;
      hit    <= 1'b0;
      pos    <= POS_W'(INIT);
    end else begin
      state  <= state_n;
      first  <= 1'b0;
      r_p    <= key_p;
      r_n    <= key_n;
      pend_p <= ~frame_tick & (pend_p | rise_p);
      pend_n <= ~frame_tick & (pend_n | rise_n);
      hit    <= go & (sum < 11'sd0 || sum > LIM);
      pos    <= !go ? pos : sum < 11'sd0 ? '0 : sum > LIM ? POS_W'(LIMIT) : sum[POS_W-1:0];
    end
  end
endmodule

// File: rtl/sprite_pos_ctrl.sv
// sprite_pos_ctrl: frame-synchronous keyboard-driven sprite position with edge clamping
//   clk, rst (async, active-high), frame_tick : timing
//   move_up/down/left/right : debounced key levels
//   pos_x, pos_y : sprite top-left; moving : any key held; edge_hit : clamp pulse
//   SPRITE_AUTO_REPEAT_EN : enables hold-to-repeat stepping
module sprite_pos_ctrl
  import sprite_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int OBJ_W        = OBJ_W_DEF,
  parameter int OBJ_H        = OBJ_H_DEF,
  parameter int STEP         = STEP_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             move_left,
  input  logic             move_right,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             moving,
  output logic             edge_hit
);
  logic held_x, held_y, hit_x, hit_y;
  axis_stepper #(
    .LIMIT(H_ACTIVE - OBJ_W), .INIT(centre(H_ACTIVE, OBJ_W)), .STEP(STEP),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_x (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .key_p(move_right), .key_n(move_left),
    .pos(pos_x), .hit(hit_x), .held(held_x)
  );
  // screen y grows downwards, so down is the positive key
  axis_stepper #(
    .LIMIT(V_ACTIVE - OBJ_H), .INIT(centre(V_ACTIVE, OBJ_H)), .STEP(STEP),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_y (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .key_p(move_down), .key_n(move_up),
    .pos(pos_y), .hit(hit_y), .held(held_y)
  );
  assign moving   = held_x | held_y;
  assign edge_hit = hit_x | hit_y;
endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// tb_sprite_pos_ctrl: directed stimulus with a queued scoreboard checked after each frame_tick
module tb_sprite_pos_ctrl;
  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000;
  typedef struct {
    string tag;
    int    x;
    int    y;
    bit    hit;
    bit    mov;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, probe = 1'b0, seen = 1'b0;
  logic [3:0] keys = 4'b0;
  logic [9:0] pos_x, pos_y;
  logic moving, edge_hit;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, ex, ey;
  bit eh;
  sprite_pos_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .move_up(keys[0]), .move_down(keys[1]), .move_left(keys[2]), .move_right(keys[3]),
    .pos_x(pos_x), .pos_y(pos_y), .moving(moving), .edge_hit(edge_hit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) seen <= frame_tick | probe;
  always @(negedge clk) begin
    if (seen) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample got x=%0d y=%0d hit=%0b mov=%0b with empty queue", pos_x, pos_y, edge_hit, moving);
      end else begin
        e = q.pop_front();
        if ({pos_x, pos_y, edge_hit, moving} !== {e.x[9:0], e.y[9:0], e.hit, e.mov}) begin
          errors++;
          $display("FAIL %s got x=%0d y=%0d hit=%0b mov=%0b want x=%0d y=%0d hit=%0b mov=%0b",
                   e.tag, pos_x, pos_y, edge_hit, moving, e.x, e.y, e.hit, e.mov);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input string tag, input int x, input int y, input bit h, input bit m);
    q.push_back('{tag, x, y, h, m});
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(2);
  endtask
  task automatic sample(input string tag, input int x, input int y, input bit h, input bit m);
    q.push_back('{tag, x, y, h, m});
    probe = 1'b1;
    cyc(1);
    probe = 1'b0;
    cyc(1);
  endtask
  task automatic tap(input logic [3:0] k);
    keys = k;
    cyc(2);
    keys = 4'b0;
    cyc(2);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask
  function automatic int rep_y(input int f);
    int s = 1;
`ifdef SPRITE_AUTO_REPEAT_EN
    if (f >= 31) s += 1 + (f - 31) / 6;
`endif
    return 224 + 8 * s;
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    sample("reset", 304, 224, 0, 0);
    tap(RT);
    frame("tap_right", 312, 224, 0, 0);
    frame("tap_no_repeat", 312, 224, 0, 0);
    keys = RT | UP | DN;
    cyc(2);
    frame("up_down_cancel", 320, 224, 0, 1);
    frame("up_down_held", 320, 224, 0, 1);
    keys = 4'b0;
    cyc(3);
    tap(RT | DN);
    frame("diagonal", 328, 232, 0, 0);
    ex = 328;
    ey = 232;
    for (int i = 0; i < 42; i++) begin
      ex -= 8;
      eh = ex < 0;
      if (eh) ex = 0;
      tap(LF);
      frame("left_edge", ex, ey, eh, 0);
    end
    for (int i = 0; i < 77; i++) begin
      ex += 8;
      eh = ex > 608;
      if (eh) ex = 608;
      tap(RT);
      frame("right_edge", ex, ey, eh, 0);
    end
    q.push_back('{"edge_at_tick", 600, 232, 0, 1});
    keys = LF;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(2);
    keys = 4'b0;
    cyc(3);
    pulse_rst();
    sample("reset_again", 304, 224, 0, 0);
    keys = DN;
    cyc(2);
    for (int f = 1; f <= 40; f++) frame("hold_down", 304, rep_y(f), 0, 1);
    keys = 4'b0;
    cyc(3);
    pulse_rst();
    keys = DN;
    cyc(2);
    for (int f = 1; f <= 35; f++) frame("hold_before_rst", 304, rep_y(f), 0, 1);
    pulse_rst();
    sample("rst_mid_hold", 304, 224, 0, 1);
    for (int f = 0; f < 3; f++) frame("held_after_rst", 304, 224, 0, 1);
    keys = 4'b0;
    cyc(3);
    tap(DN);
    frame("repress_after_rst", 304, 232, 0, 0);
    for (int i = 0; i < 50 && q.size() > 0; i++) cyc(1);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
